// File: rtl/oam_dma_engine.sv
// OAM DMA: a CPU write to FF46 copies 160 bytes from {src,00..9F} into OAM FE00-FE9F.
// Latency: 1 SETUP clock, then CYCLES_PER_BYTE clocks per byte (1 + 160*CYCLES_PER_BYTE busy clocks).
// No backpressure: fixed pacing; a new FF46 write aborts and restarts the copy from index 0.
module oam_dma_engine #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int READ_LATENCY    = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iCpuWe,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oDmaReg,
  output logic        oDmaBusy,
  output logic        oDmaReadReq,
  output logic [15:0] oDmaAddr,
  input  logic [7:0]  iDmaReadData,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam logic [3:0] PACE_LAST = 4'(CYCLES_PER_BYTE - 1);
  localparam logic [3:0] PACE_RD   = 4'(READ_LATENCY);
  localparam logic [7:0] IDX_LAST  = 8'd159;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] idx;
  logic [3:0] pace;
  logic [7:0] src;
  logic       trig;
  logic       rd_fire;
  logic       wr_fire;
  logic       byte_done;

  assign trig      = iCpuWe && (iCpuAddr == 16'hFF46);
  assign byte_done = (state == XFER) && (pace == PACE_LAST);
  assign oDmaBusy  = (state != IDLE);

  // State register; reset takes priority over any trigger in the same cycle.
  always_ff @(posedge iClock) begin
    if (!iReset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and strobe decode; a trigger overrides everything and kills pending strobes.
  always_comb begin
    state_nxt = state;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    case (state)
      IDLE:  state_nxt = IDLE;
      SETUP: state_nxt = XFER;
      XFER: begin
        rd_fire = (pace == 4'd0);
        wr_fire = (pace == PACE_RD);
        if (byte_done && (idx == IDX_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (trig) begin
      state_nxt = SETUP;
      rd_fire   = 1'b0;
      wr_fire   = 1'b0;
    end
  end

  // Datapath: register latch, pacing counters, source fold and registered bus strobes.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      oDmaReg     <= 8'h00;
      oDmaReadReq <= 1'b0;
      oDmaAddr    <= 16'h0000;
      oOamWe      <= 1'b0;
      oOamAddr    <= 8'h00;
      oOamData    <= 8'h00;
      idx         <= 8'h00;
      pace        <= 4'h0;
      src         <= 8'h00;
    end else begin
      oDmaReadReq <= rd_fire;
      oOamWe      <= wr_fire;
      if (trig) oDmaReg <= iCpuData;
      if (state == SETUP) begin
        idx  <= 8'h00;
        pace <= 4'h0;
        // E0-FF is echo RAM; fold it back onto C0-DF.
        src  <= (oDmaReg >= 8'hE0) ? (oDmaReg - 8'h20) : oDmaReg;
      end else if (state == XFER) begin
        pace <= byte_done ? 4'h0 : (pace + 4'd1);
        if (byte_done && (idx != IDX_LAST)) idx <= idx + 8'd1;
      end
      if (rd_fire) oDmaAddr <= {src, idx};
      if (wr_fire) begin
        oOamAddr <= idx;
        oOamData <= iDmaReadData;
      end
    end
  end

endmodule
